// File: rtl/o_feature_store_pkg.sv
// o_feature_store shared definitions.
// Widths, transfer FSM encoding and small helpers.
package o_feature_store_pkg;

    localparam int DATA_W = 128;
    localparam int EXT_AW = 16;
    localparam int BUF_AW = 15;
    localparam int RD_LAT = 2;
    localparam int FIFO_D = 4;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = $clog2(FIFO_D + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } store_st_e;

    // Number of reads still travelling through the on-chip read pipe.
    function automatic logic [CNT_W-1:0] vld_count(
        input logic [RD_LAT-1:0] v
    );
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/o_feature_store_skid_fifo.sv
// store_skid_fifo: small synchronous FIFO absorbing external back-pressure.
// The head word is held in its own register so ext_data comes from a flop.
module store_skid_fifo
    import o_feature_store_pkg::*;
#(
    parameter int DEPTH = FIFO_D,
    parameter int WIDTH = DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_nxt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_nxt  = ptr_inc(rd_ptr);

    // Storage array; occupancy is tracked by count, so no reset here.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= rd_nxt;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
            if (do_pop) begin
                if (count > CW'(1)) begin
                    head <= mem[rd_nxt];
                end else if (do_push) begin
                    head <= push_data;
                end
            end else if (empty && do_push) begin
                head <= push_data;
            end
        end
    end

    // The read credit scheme must never push into a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/o_feature_store.sv
// o_feature_store: drains words from on-chip output feature memory
// to external memory, with credit-limited reads and a skid FIFO.
module o_feature_store
    import o_feature_store_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              store_enable,
    input  logic [7:0]        store_type,
    input  logic [7:0]        src_addr,
    input  logic [EXT_AW-1:0] dst_addr,
    input  logic [7:0]        mem_sel,
    input  logic [LEN_W-1:0]  length,
    output logic [BUF_AW-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              o_mem_select,
    output logic [EXT_AW-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_data,
    output logic              ext_wr_en,
    input  logic              ext_ready,
    output logic              busy,
    output logic              done
);

    store_st_e         state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  written;
    logic [RD_LAT-1:0] vld;
    logic [CNT_W-1:0]  in_flight;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              credit_ok;
    logic              ext_pop;
    logic              unused_ok;

    assign unused_ok = ^{store_type[7:1], mem_sel[7:1], fifo_full};

    assign ext_wr_en = !fifo_empty;
    assign ext_pop   = ext_wr_en && ext_ready;

    // Issue a read only while every outstanding word has a FIFO slot.
    always_comb begin
        in_flight = vld_count(vld);
        credit_ok = ({1'b0, in_flight} + {1'b0, fifo_count})
                    < (CNT_W + 1)'(FIFO_D);
        rd_en     = (state == ST_RUN) && (issued != len_q) && credit_ok;
    end

    // Read-valid pipe matching the on-chip memory latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld <= {vld[RD_LAT-2:0], rd_en};
        end
    end

    store_skid_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld[RD_LAT-1]),
        .push_data (rd_data),
        .pop       (ext_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (ext_data)
    );

    // Transfer FSM with its address/beat counters and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            issued       <= '0;
            written      <= '0;
            rd_addr      <= '0;
            ext_addr     <= '0;
            o_mem_select <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ext_pop) begin
                ext_addr <= ext_addr + EXT_AW'(1);
                written  <= written + LEN_W'(1);
            end
            if (rd_en) begin
                rd_addr <= rd_addr + BUF_AW'(1);
                issued  <= issued + LEN_W'(1);
            end
            unique case (state)
                ST_IDLE: begin
                    if (store_enable) begin
                        o_mem_select <= mem_sel[0] | store_type[0];
                        rd_addr      <= BUF_AW'(src_addr);
                        ext_addr     <= dst_addr;
                        len_q        <= length;
                        issued       <= '0;
                        written      <= '0;
                        busy         <= 1'b1;
                        state        <= (length == '0) ? ST_DONE
                                                       : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rd_en && (issued + LEN_W'(1) == len_q)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ext_pop && (written + LEN_W'(1) == len_q)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_o_feature_store.sv
// tb_o_feature_store: random and directed transfers against a
// queue-based model of the expected read and write streams.
module tb_o_feature_store;
    import o_feature_store_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              store_enable;
    logic [7:0]        store_type;
    logic [7:0]        src_addr;
    logic [EXT_AW-1:0] dst_addr;
    logic [7:0]        mem_sel;
    logic [7:0]        length;
    logic [BUF_AW-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              o_mem_select;
    logic [EXT_AW-1:0] ext_addr;
    logic [DATA_W-1:0] ext_data;
    logic              ext_wr_en;
    logic              ext_ready;
    logic              busy;
    logic              done;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic [31:0]       salt;
    logic [DATA_W-1:0] pipe0;
    logic [DATA_W-1:0] pipe1;

    o_feature_store dut (
        .clk          (clk),
        .rst          (rst),
        .store_enable (store_enable),
        .store_type   (store_type),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .mem_sel      (mem_sel),
        .length       (length),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .o_mem_select (o_mem_select),
        .ext_addr     (ext_addr),
        .ext_data     (ext_data),
        .ext_wr_en    (ext_wr_en),
        .ext_ready    (ext_ready),
        .busy         (busy),
        .done         (done)
    );

    function automatic logic [DATA_W-1:0] memw(
        input logic bank, input logic [BUF_AW-1:0] a
    );
        logic [15:0] k;
        k = {bank, a};
        return {salt, k, ~k, salt ^ 32'hA5A5_5A5A, k * 16'd7, k ^ 16'h1234};
    endfunction

    task automatic check(input string tag,
                         input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rd_data = pipe1;
        pipe1   = pipe0;
        pipe0   = rd_en ? memw(o_mem_select, rd_addr)
                        : {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_act", {rd_en, ext_wr_en, busy, done}, '0);
        end
    endtask

    task automatic xfer(input logic [7:0] src, input logic [15:0] dst,
                        input logic [7:0] len, input int mode,
                        input bit reissue, input int abort_at);
        logic [DATA_W-1:0] exp_d[$];
        logic [EXT_AW-1:0] exp_a[$];
        logic [BUF_AW-1:0] exp_r[$];
        logic [7:0] st;
        logic [7:0] ms;
        logic bank;
        int t0, first_rd, first_wr, last_hs, reads, beats, stall;
        bit fin;
        st   = 8'($urandom);
        ms   = 8'($urandom);
        bank = ms[0] | st[0];
        for (int i = 0; i < int'(len); i++) begin
            exp_r.push_back(BUF_AW'(src) + BUF_AW'(i));
            exp_a.push_back(dst + EXT_AW'(i));
            exp_d.push_back(memw(bank, BUF_AW'(src) + BUF_AW'(i)));
        end
        store_enable = 1'b1;
        store_type   = st;
        mem_sel      = ms;
        src_addr     = src;
        dst_addr     = dst;
        length       = len;
        t0 = cyc; first_rd = -1; first_wr = -1; last_hs = -1;
        reads = 0; beats = 0; stall = 0; fin = 0;
        for (int k = 0; k < 2000 && !fin; k++) begin
            step();
            store_enable = 1'b0;
            if (reissue && k == 2) begin
                store_enable = 1'b1;
                mem_sel      = ~ms;
                store_type   = ~st;
                length       = 8'($urandom);
                src_addr     = 8'($urandom);
                dst_addr     = 16'($urandom);
            end
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (exp_r.size() == 0) check("rd_extra", rd_en, 0);
                else check("rd_addr", rd_addr, exp_r.pop_front());
                check("credit", (reads + 1 - beats) <= FIFO_D, 1);
                reads++;
            end
            case (mode)
                0: ext_ready = 1'b1;
                1: ext_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (first_wr >= 0 && cyc == first_wr + 2) stall = 5;
                    ext_ready = (stall == 0);
                    if (stall > 0) stall--;
                end
            endcase
            if (ext_wr_en) begin
                if (first_wr < 0) begin
                    first_wr = cyc;
                    check("first_lat", first_wr - first_rd, RD_LAT + 1);
                end
                if (exp_d.size() == 0) check("wr_extra", ext_wr_en, 0);
                else begin
                    check("ext_addr", ext_addr, exp_a[0]);
                    check("ext_data", ext_data, exp_d[0]);
                    if (ext_ready) begin
                        void'(exp_a.pop_front());
                        void'(exp_d.pop_front());
                        beats++;
                        last_hs = cyc;
                    end
                end
            end else if (mode == 0 && first_wr >= 0 && beats < int'(len)) begin
                check("b2b", ext_wr_en, 1);
            end
            check("mem_sel", o_mem_select, bank);
            if (done) begin
                check("done_cyc", cyc, (len == 0) ? t0 + 2 : last_hs + 2);
                check("busy_at_done", busy, 0);
                check("beats", beats, len);
                check("reads", reads, len);
                fin = 1;
            end else begin
                check("busy", busy, 1);
            end
            if (abort_at >= 0 && first_rd >= 0 && cyc == first_rd + abort_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check("abort_zero", {rd_addr, rd_en, o_mem_select, ext_addr,
                                     ext_wr_en, busy, done}, '0);
                check("abort_data", ext_data, '0);
                idle(6);
                return;
            end
        end
        if (!fin) check("timeout", fin, 1);
    endtask

    initial begin
        salt         = $urandom;
        pipe0        = '0;
        pipe1        = '0;
        rd_data      = '0;
        rst          = 1'b1;
        store_enable = 1'b0;
        store_type   = '0;
        src_addr     = '0;
        dst_addr     = '0;
        mem_sel      = '0;
        length       = '0;
        ext_ready    = 1'b1;
        step();
        step();
        check("rst_zero", {rd_addr, rd_en, o_mem_select, ext_addr,
                           ext_wr_en, busy, done}, '0);
        check("rst_data", ext_data, '0);
        rst = 1'b0;
        idle(2);
        xfer(8'h10, 16'h0200, 8'd4, 0, 0, -1);
        idle(1);
        xfer(8'($urandom), 16'($urandom), 8'd8, 2, 0, -1);
        xfer(8'($urandom), 16'($urandom), 8'd0, 0, 0, -1);
        idle(1);
        xfer(8'($urandom), 16'hFFFE, 8'd4, 0, 0, -1);
        xfer(8'($urandom), 16'($urandom), 8'd6, 0, 0, 2);
        xfer(8'($urandom), 16'($urandom), 8'd2, 0, 0, -1);
        xfer(8'($urandom), 16'($urandom), 8'd8, 1, 1, -1);
        for (int i = 0; i < 25; i++) begin
            xfer(8'($urandom), 16'($urandom), 8'($urandom_range(0, 40)),
                 int'($urandom_range(0, 1)), 0, -1);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
